// File: rtl/mux_2x1.sv
// Registered 2:1 multiplexer with a configurable-depth output pipeline.
// Stage 0 captures the mux result, in_valid and sel. Each later stage copies the
// stage before it. The last stage drives the outputs. en freezes the whole pipe,
// and rst clears it synchronously. rst takes priority over en.
module mux_2x1 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             sel_out
);

  // Index 0 of each chain is the new sample. Index k is the output of stage k-1.
  // Using the chains keeps every slice constant, including when LATENCY == 1.
  logic [LATENCY:0][WIDTH-1:0]   data_chain;
  logic [LATENCY:0]              valid_chain;
  logic [LATENCY:0]              sel_chain;

  logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;
  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0]            sel_q, sel_d;

  // Next state: the selected operand enters stage 0, and every stage shifts down one.
  always_comb begin
    data_chain  = {data_q, (sel ? data1 : data0)};
    valid_chain = {valid_q, in_valid};
    sel_chain   = {sel_q, sel};
    data_d      = data_chain[LATENCY-1:0];
    valid_d     = valid_chain[LATENCY-1:0];
    sel_d       = sel_chain[LATENCY-1:0];
  end

  // Pipeline registers. A reset clears everything in flight. en gates the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      sel_q   <= '0;
    end else if (en) begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign data_out  = data_q[LATENCY-1];
  assign out_valid = valid_q[LATENCY-1];
  assign sel_out   = sel_q[LATENCY-1];

endmodule

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1. Three instances (LATENCY 1, 3, 4) share one stimulus bus.
module tb_mux_2x1;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, sel;
  logic [31:0] data0, data1;
  logic [31:0] q1, q3, q4;
  logic        v1, v3, v4, s1, s3, s4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_2x1 #(.WIDTH(32), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data0(data0), .data1(data1),
    .sel(sel), .data_out(q1), .out_valid(v1), .sel_out(s1)
  );
  mux_2x1 #(.WIDTH(32), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data0(data0), .data1(data1),
    .sel(sel), .data_out(q3), .out_valid(v3), .sel_out(s3)
  );
  mux_2x1 #(.WIDTH(32), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data0(data0), .data1(data1),
    .sel(sel), .data_out(q4), .out_valid(v4), .sel_out(s4)
  );

  // Inputs change on the falling edge. Outputs are read on the falling edge before new drive.
  task automatic drive(input logic r, input logic e, input logic v, input logic s,
                       input logic [31:0] d0, input logic [31:0] d1);
    rst = r; en = e; in_valid = v; sel = s; data0 = d0; data1 = d1;
  endtask

  // Reset while en is low must still clear every stage.
  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({q1, v1, s1} !== 34'h0) begin
      n_bad++; $display("FAIL reset_l1: got %h/%b/%b want 0/0/0", q1, v1, s1);
    end
    n_cmp++;
    if ({q3, v3, s3} !== 34'h0) begin
      n_bad++; $display("FAIL reset_l3: got %h/%b/%b want 0/0/0", q3, v3, s3);
    end
    n_cmp++;
    if ({q4, v4, s4} !== 34'h0) begin
      n_bad++; $display("FAIL reset_l4: got %h/%b/%b want 0/0/0", q4, v4, s4);
    end
  endtask

  // LATENCY=1 test. data0=1 and data1=2. sel toggles every cycle starting at 0.
  task automatic test_toggle();
    logic [31:0] exp_d;
    logic        exp_s;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        exp_s = ((j - 1) % 2) == 1;
        exp_d = exp_s ? 32'h2 : 32'h1;
        n_cmp++;
        if (q1 !== exp_d || v1 !== 1'b1 || s1 !== exp_s) begin
          n_bad++;
          $display("FAIL toggle[%0d]: got %h/%b/%b want %h/1/%b", j, q1, v1, s1, exp_d, exp_s);
        end
      end
      drive(1'b0, 1'b1, 1'b1, 1'(j % 2), 32'h1, 32'h2);
    end
  endtask

  // Operand pairs (3,4), (5,6), (7,8), each held for two cycles with sel = 0, 1.
  task automatic test_stream();
    logic [31:0] exp_tab [6];
    exp_tab = '{32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j >= 1 && j <= 6) begin
        n_cmp++;
        if (q1 !== exp_tab[j-1] || v1 !== 1'b1) begin
          n_bad++;
          $display("FAIL stream_l1[%0d]: got %0d/%b want %0d/1", j, q1, v1, exp_tab[j-1]);
        end
      end
      if (j >= 3) begin
        n_cmp++;
        if (q3 !== exp_tab[j-3] || v3 !== 1'b1) begin
          n_bad++;
          $display("FAIL stream_l3[%0d]: got %0d/%b want %0d/1", j, q3, v3, exp_tab[j-3]);
        end
      end
      if (j < 6) drive(1'b0, 1'b1, 1'b1, 1'(j % 2), 32'(3 + 2 * (j / 2)), 32'(4 + 2 * (j / 2)));
      else       drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  // LATENCY=3 test. One valid sample is surrounded by idle cycles, giving one pulse 3 cycles later.
  task automatic test_single_pulse();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        n_cmp++;
        if (v3 !== (j == 3)) begin
          n_bad++; $display("FAIL pulse_valid[%0d]: got %b want %b", j, v3, (j == 3));
        end
      end
      if (j == 3) begin
        n_cmp++;
        if (q3 !== 32'hDEAD_BEEF || s3 !== 1'b1) begin
          n_bad++; $display("FAIL pulse_data: got %h/%b want deadbeef/1", q3, s3);
        end
      end
      if (j == 0) drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
      else        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  // en is held low for 4 cycles mid-stream. The garbage driven during the stall must be ignored.
  task automatic test_enable_stall();
    logic [31:0] exp_d [13];
    logic        exp_v [13];
    exp_d = '{32'd10, 32'd11, 32'd11, 32'd11, 32'd11, 32'd11, 32'd12,
              32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd0};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        n_cmp++;
        if (q3 !== exp_d[j-3] || v3 !== exp_v[j-3] || s3 !== 1'b0) begin
          n_bad++;
          $display("FAIL stall[%0d]: got %0d/%b/%b want %0d/%b/0",
                   j, q3, v3, s3, exp_d[j-3], exp_v[j-3]);
        end
      end
      if (j < 4)       drive(1'b0, 1'b1, 1'b1, 1'b0, 32'(10 + j), 32'h0);
      else if (j < 8)  drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD, 32'hBAD0);
      else if (j < 12) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'(14 + j - 8), 32'h0);
      else             drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  // LATENCY=4 test. Fill the pipeline, then pulse rst with en high.
  // In-flight samples must vanish, and a new sample takes exactly 4 cycles.
  task automatic test_reset_midstream();
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 4) begin
        n_cmp++;
        if (q4 !== 32'(32'h100 + j - 4) || v4 !== 1'b1 || s4 !== 1'b1) begin
          n_bad++;
          $display("FAIL fill_l4[%0d]: got %h/%b/%b want %h/1/1", j, q4, v4, s4, 32'h100 + j - 4);
        end
      end
      if (j < 6) drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'(32'h100 + j));
      else       drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1FF);
    end
    @(negedge clk);
    n_cmp++;
    if ({q4, v4, s4} !== 34'h0) begin
      n_bad++; $display("FAIL midreset_clear: got %h/%b/%b want 0/0/0", q4, v4, s4);
    end
    for (int k = 0; k < 9; k++) begin
      if (k >= 1) begin
        n_cmp++;
        if (v4 !== (k == 7) || q4 !== ((k == 7) ? 32'h55 : 32'h0)) begin
          n_bad++;
          $display("FAIL midreset_refill[%0d]: got %h/%b want %h/%b",
                   k, q4, v4, ((k == 7) ? 32'h55 : 32'h0), (k == 7));
        end
      end
      if (k == 3) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h0);
      else        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  // All-ones against all-zeros operands checks every bit of the select.
  // A sample with in_valid low still propagates its data.
  task automatic test_width_bits();
    logic [31:0] exp_d;
    logic        exp_s;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        exp_s = ((j - 1) % 2) == 1;
        exp_d = exp_s ? 32'h0000_0000 : 32'hFFFF_FFFF;
        n_cmp++;
        if (q1 !== exp_d || v1 !== 1'b1 || s1 !== exp_s) begin
          n_bad++;
          $display("FAIL width[%0d]: got %h/%b/%b want %h/1/%b", j, q1, v1, s1, exp_d, exp_s);
        end
      end
      if (j < 6) drive(1'b0, 1'b1, 1'b1, 1'(j % 2), 32'hFFFF_FFFF, 32'h0);
      else       drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5_5A5A);
    end
    @(negedge clk);
    n_cmp++;
    if (q1 !== 32'hA5A5_5A5A || v1 !== 1'b0 || s1 !== 1'b1) begin
      n_bad++; $display("FAIL invalid_propagate: got %h/%b/%b want a5a55a5a/0/1", q1, v1, s1);
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_stream();
    test_single_pulse();
    test_enable_stall();
    test_reset_midstream();
    test_width_bits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
